// File: rtl/wts_pkg.sv
// wts_pkg: shared widths, channel index type and slot wrap helper for the wave-table tone generator.
package wts_pkg;
  localparam int WTS_CH_NUM   = 12;
  localparam int WTS_FREQ_W   = 12;
  localparam int WTS_PTR_W    = 5;
  localparam int WTS_SAMPLE_W = 8;
  localparam int WTS_ADDR_W   = 9;
  typedef logic [3:0] wts_ch_t;
  localparam wts_ch_t WTS_LAST_CH = 4'd11;
  function automatic wts_ch_t wts_next_ch(input wts_ch_t c);
    return (c == WTS_LAST_CH) ? '0 : c + 1'b1;
  endfunction
endpackage

// File: rtl/wts_slot_sequencer.sv
// wts_slot_sequencer: 0..11 service slot, read/sample pipeline stage channel indices and frame marker.
module wts_slot_sequencer
  import wts_pkg::*;
(
  input  logic    nreset,
  input  logic    clk,
  output wts_ch_t o_slot,
  output logic    o_rd,
  output wts_ch_t o_rd_ch,
  output logic    o_sample_valid,
  output wts_ch_t o_sample_ch,
  output logic    o_frame_start
);
  wts_ch_t r_slot, r_rd_ch, r_sample_ch;
  logic    r_rd, r_sample_valid, r_frame_start;
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_slot         <= '0;
      r_rd           <= 1'b0;
      r_rd_ch        <= '0;
      r_sample_valid <= 1'b0;
      r_sample_ch    <= '0;
      r_frame_start  <= 1'b0;
    end else begin
      r_slot         <= wts_next_ch(r_slot);
      r_rd           <= 1'b1;
      r_rd_ch        <= r_slot;
      r_sample_valid <= r_rd;
      r_sample_ch    <= r_rd_ch;
      r_frame_start  <= r_rd && (r_rd_ch == '0);
    end
  end
  assign o_slot         = r_slot;
  assign o_rd           = r_rd;
  assign o_rd_ch        = r_rd_ch;
  assign o_sample_valid = r_sample_valid;
  assign o_sample_ch    = r_sample_ch;
  assign o_frame_start  = r_frame_start;
endmodule

// File: rtl/wts_tone_generator.sv
// wts_tone_generator: time-multiplexed 12-channel wave-table pointer stepping and sample fetch.
module wts_tone_generator
  import wts_pkg::*;
(
  input  logic                    nreset,
  input  logic                    clk,
  input  logic                    i_reg_freq_wr,
  input  wts_ch_t                 i_reg_freq_ch,
  input  logic [WTS_FREQ_W-1:0]   i_reg_freq_data,
  input  logic [WTS_CH_NUM-1:0]   i_reg_key_on,
  output logic [WTS_ADDR_W-1:0]   o_wave_address,
  output logic                    o_wave_rd,
  input  logic [WTS_SAMPLE_W-1:0] i_wave_data,
  output logic                    o_sample_valid,
  output wts_ch_t                 o_sample_ch,
  output logic [WTS_SAMPLE_W-1:0] o_sample_data,
  output logic                    o_frame_start
);
  logic [WTS_FREQ_W-1:0]   r_freq [WTS_CH_NUM];
  logic [WTS_FREQ_W-1:0]   r_cnt  [WTS_CH_NUM];
  logic [WTS_PTR_W-1:0]    r_ptr  [WTS_CH_NUM];
  logic [WTS_PTR_W-1:0]    r_rd_ptr;
  logic                    r_key_s1;
  logic [WTS_SAMPLE_W-1:0] r_sample_data;
  wts_ch_t                 w_slot, w_rd_ch;
  logic                    w_key, w_cnt_zero;

  wts_slot_sequencer u_seq (
    .nreset        (nreset),
    .clk           (clk),
    .o_slot        (w_slot),
    .o_rd          (o_wave_rd),
    .o_rd_ch       (w_rd_ch),
    .o_sample_valid(o_sample_valid),
    .o_sample_ch   (o_sample_ch),
    .o_frame_start (o_frame_start)
  );

  assign w_key      = i_reg_key_on[w_slot];
  assign w_cnt_zero = (r_cnt[w_slot] == '0);

  // Non-blocking write: a reload in the same clk still sees the old period.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < WTS_CH_NUM; i++) r_freq[i] <= '0;
    end else if (i_reg_freq_wr && i_reg_freq_ch <= WTS_LAST_CH) begin
      r_freq[i_reg_freq_ch] <= i_reg_freq_data;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < WTS_CH_NUM; i++) begin
        r_cnt[i] <= '0;
        r_ptr[i] <= '0;
      end
      r_rd_ptr      <= '0;
      r_key_s1      <= 1'b0;
      r_sample_data <= '0;
    end else begin
      r_cnt[w_slot] <= (!w_key || w_cnt_zero) ? r_freq[w_slot] : r_cnt[w_slot] - 1'b1;
      r_ptr[w_slot] <= !w_key ? '0 : w_cnt_zero ? r_ptr[w_slot] + 1'b1 : r_ptr[w_slot];
      r_rd_ptr      <= r_ptr[w_slot];
      r_key_s1      <= w_key;
      r_sample_data <= r_key_s1 ? i_wave_data : '0;
    end
  end

  assign o_wave_address = {w_rd_ch, r_rd_ptr};
  assign o_sample_data  = r_sample_data;
endmodule

// File: tb/tb_wts_tone_generator.sv
// tb_wts_tone_generator: directed steps plus a queue scoreboard fed by a frame-level reference model.
module tb_wts_tone_generator;
  import wts_pkg::*;
  typedef struct packed {logic [3:0] ch; logic [7:0] d;} smp_t;

  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic        freq_wr = 1'b0;
  logic [3:0]  freq_ch = '0;
  logic [11:0] freq_data = '0;
  logic [11:0] key_on = '0;
  logic [8:0]  wave_address;
  logic        wave_rd;
  logic [7:0]  wave_data;
  logic        sample_valid;
  logic [3:0]  sample_ch;
  logic [7:0]  sample_data;
  logic        frame_start;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  assign wave_data = {3'b000, wave_address[4:0]};

  wts_tone_generator dut (
    .nreset         (nreset),
    .clk            (clk),
    .i_reg_freq_wr  (freq_wr),
    .i_reg_freq_ch  (freq_ch),
    .i_reg_freq_data(freq_data),
    .i_reg_key_on   (key_on),
    .o_wave_address (wave_address),
    .o_wave_rd      (wave_rd),
    .i_wave_data    (wave_data),
    .o_sample_valid (sample_valid),
    .o_sample_ch    (sample_ch),
    .o_sample_data  (sample_data),
    .o_frame_start  (frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: frame-level behaviour, pushes expected address and sample per serviced slot.
  smp_t        smp_q[$];
  logic [8:0]  adr_q[$];
  logic [11:0] m_freq [12];
  logic [11:0] m_cnt  [12];
  logic [4:0]  m_ptr  [12];
  int          m_slot;
  smp_t        ms, s;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_slot = 0;
      for (int i = 0; i < 12; i++) begin
        m_freq[i] = '0;
        m_cnt[i]  = '0;
        m_ptr[i]  = '0;
      end
      smp_q.delete();
      adr_q.delete();
    end else begin
      adr_q.push_back({4'(m_slot), m_ptr[m_slot]});
      ms.ch = 4'(m_slot);
      ms.d  = key_on[m_slot] ? {3'b000, m_ptr[m_slot]} : 8'h00;
      smp_q.push_back(ms);
      if (!key_on[m_slot]) begin
        m_cnt[m_slot] = m_freq[m_slot];
        m_ptr[m_slot] = '0;
      end else if (m_cnt[m_slot] == 0) begin
        m_cnt[m_slot] = m_freq[m_slot];
        m_ptr[m_slot] = m_ptr[m_slot] + 5'd1;
      end else begin
        m_cnt[m_slot] = m_cnt[m_slot] - 12'd1;
      end
      if (freq_wr && freq_ch < 4'd12) m_freq[freq_ch] = freq_data;
      m_slot = (m_slot + 1) % 12;
    end
  end

  always @(negedge clk) begin
    if (!nreset) begin
      chk("rst_outs", {wave_rd, sample_valid, frame_start, wave_address, sample_ch, sample_data}, 0);
    end else begin
      chk("sb_rd", wave_rd, adr_q.size() >= 1);
      chk("sb_valid", sample_valid, smp_q.size() >= 2);
      if (wave_rd && adr_q.size() > 0) chk("sb_addr", wave_address, adr_q.pop_front());
      if (sample_valid && smp_q.size() > 0) begin
        s = smp_q.pop_front();
        chk("sb_ch", sample_ch, s.ch);
        chk("sb_data", sample_data, s.d);
        chk("sb_frame", frame_start, s.ch == 4'd0);
      end
    end
  end

  task automatic wait_addr(input logic [3:0] c);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (wave_rd && wave_address[8:5] == c) return;
    end
    chk("wait_addr_timeout", wave_address[8:5], c);
  endtask

  task automatic wait_smp(input logic [3:0] c);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sample_valid && sample_ch == c) return;
    end
    chk("wait_smp_timeout", sample_ch, c);
  endtask

  task automatic write_freq(input logic [3:0] c, input logic [11:0] f);
    freq_wr   = 1'b1;
    freq_ch   = c;
    freq_data = f;
    @(negedge clk);
    freq_wr = 1'b0;
  endtask

  logic [4:0] exp_wr [9] = '{5'd2, 5'd2, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd4};
  int         fs;
  logic [7:0] acc;
  logic [4:0] p;

  initial begin
    #1 nreset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_addr", wave_address, 0);
    #2 nreset = 1'b1;
    @(negedge clk);
    chk("first_rd", {wave_rd, sample_valid, wave_address}, {1'b1, 1'b0, 9'd0});
    @(negedge clk);
    chk("first_smp", {sample_valid, sample_ch, frame_start}, {1'b1, 4'd0, 1'b1});
    fs = 0;
    acc = '0;
    repeat (24) begin
      @(negedge clk);
      fs += int'(frame_start);
      acc |= sample_data;
    end
    chk("frame_cnt", fs, 2);
    chk("silent_data", acc, 0);

    write_freq(4'd3, 12'd0);
    wait_smp(4'd3);
    key_on[3] = 1'b1;
    for (int k = 0; k < 33; k++) begin
      wait_addr(4'd3);
      chk("f0_addr", wave_address, {4'd3, 5'(k % 32)});
      @(negedge clk);
      chk("f0_smp", {sample_ch, sample_data}, {4'd3, 8'(k % 32)});
    end

    write_freq(4'd11, 12'd2);
    repeat (12) @(negedge clk);
    wait_smp(4'd11);
    key_on[11] = 1'b1;
    for (int k = 0; k < 97; k++) begin
      wait_smp(4'd11);
      chk("f2_data", sample_data, 8'((k / 3) % 32));
    end

    write_freq(4'd0, 12'd1);
    repeat (12) @(negedge clk);
    wait_smp(4'd0);
    key_on[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_addr(4'd0);
      if (wave_address[4:0] == 5'd1) break;
    end
    wait_addr(4'd11);
    write_freq(4'd0, 12'd5);
    chk("wr_same_addr", wave_address, {4'd0, 5'd1});
    for (int i = 0; i < 9; i++) begin
      wait_addr(4'd0);
      chk("wr_same_seq", wave_address, {4'd0, exp_wr[i]});
    end

    wait_smp(4'd7);
    key_on[7] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wait_addr(4'd7);
      if (wave_address[4:0] == 5'd17) break;
    end
    key_on[7] = 1'b0;
    @(negedge clk);
    chk("koff_last", {sample_ch, sample_data}, {4'd7, 8'd17});
    wait_addr(4'd7);
    chk("koff_addr", wave_address, {4'd7, 5'd18});
    @(negedge clk);
    chk("koff_zero", {sample_ch, sample_data}, {4'd7, 8'd0});
    key_on[7] = 1'b1;
    wait_addr(4'd7);
    chk("kon_addr0", wave_address, {4'd7, 5'd0});
    wait_addr(4'd7);
    chk("kon_addr1", wave_address, {4'd7, 5'd1});
    @(negedge clk);
    chk("kon_smp1", {sample_ch, sample_data}, {4'd7, 8'd1});

    write_freq(4'd13, 12'h007);
    repeat (12) @(negedge clk);
    wait_addr(4'd3);
    p = wave_address[4:0];
    wait_addr(4'd3);
    chk("bad_ch_f0", wave_address, {4'd3, 5'(p + 5'd1)});

    @(negedge clk);
    #2 nreset = 1'b0;
    #1 chk("async_rst", {wave_rd, sample_valid, frame_start, wave_address, sample_ch, sample_data}, 0);
    repeat (3) @(negedge clk);
    #2 nreset = 1'b1;
    wait_addr(4'd3);
    chk("post_rst_ptr", wave_address, {4'd3, 5'd0});
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wts_tone_generator.md
# wts_tone_generator

Time-multiplexed wave-table tone generator for the 12 Wave Table Sound channels (set 0: A0–F0, set 1: A1–F1). It keeps a per-channel period counter and 5-bit sample pointer, and fetches one 8-bit signed sample per channel slot from the external wave RAM. It presents the sample stream to the channel mixer, which applies per-channel volume and left/right enable.

## Interface
- Parameters: none; all widths come from `wts_pkg`.
- `nreset` input 1: asynchronous, active-low reset.
- `clk` input 1: clock.
- `reg_freq_wr` input 1: one-cycle write strobe for a frequency register.
- `reg_freq_ch` input 4: target channel, 0–11. Values 12–15 are ignored.
- `reg_freq_data` input 12: period value, F.
- `reg_key_on` input 12: per-channel level enable; bit n is channel n.
- `wave_address` output 9: wave RAM address `{ch[3:0], ptr[4:0]}`.
- `wave_rd` output 1: wave RAM read strobe.
- `wave_data` input 8: RAM read data, valid exactly 1 clk after `wave_rd`.
- `sample_valid` output 1: `sample_ch` and `sample_data` are valid this cycle.
- `sample_ch` output 4: channel index of the current sample.
- `sample_data` output 8: signed two's-complement sample.
- `frame_start` output 1: high together with `sample_valid` when `sample_ch == 0`.

## Operation
**Slot counter**
- `slot` runs 0..11 and wraps; it advances 1 every clk.
- One channel is serviced per clk, so a frame is 12 clk.

**Per-channel state**
- `freq[n]` (12b), `cnt[n]` (12b down-counter), `ptr[n]` (5b).

**Stage 0, on the visit to channel n = slot**
- Issue `wave_rd` = 1 with `wave_address = {n, ptr[n]}`, using `ptr` before any update.
- If `key_on[n]` = 0: set `cnt[n]` ← `freq[n]` and `ptr[n]` ← 0.
- Else if `cnt[n]` == 0: set `cnt[n]` ← `freq[n]` and `ptr[n]` ← `ptr[n]` + 1, wrapping 31→0.
- Otherwise: `cnt[n]` ← `cnt[n]` − 1.

**Stage 1, one clk later**
- `sample_valid` = 1 and `sample_ch` = n.
- `sample_data` = `wave_data` if `key_on[n]` was 1 at stage 0; otherwise 8'h00.

**Tone period**
- One sample step every (F+1) frames.
- Full waveform period = 32·(F+1)·12 clk.
- F = 0 steps the pointer on every visit.

**Register writes**
- Write port: `freq[reg_freq_ch]` ← `reg_freq_data` on `reg_freq_wr`.
- `cnt` is not disturbed by a write; the new value is used at the next reload.

**Boundary conditions**
- A write to the channel being serviced in the same clk: stage 0 reload uses the old `freq`; the new value is used from the next reload.
- A write with `ch` ≥ 12 has no effect.
- Key-on 0→1: the first sample is `ptr` = 0, read on that visit; the first step occurs F+1 visits later.
- Key-off mid-waveform: the pointer resets at the next visit, and output is 0 from that visit.

## Timing
- Reset values: `slot` = 0; all `freq`, `cnt`, `ptr` = 0; `wave_rd` = 0; `wave_address` = 0; `sample_valid` = 0; `sample_ch` = 0; `sample_data` = 0; `frame_start` = 0.
- First clk after reset release: stage 0 services channel 0.
- Outputs are registered.
- `wave_rd` is high every clk after the first post-reset clk.
- Latency: `sample_valid` for channel n appears 1 clk after its `wave_rd`, i.e. 2 clk after `slot` = n is presented internally.
- Steady state: `sample_valid` is high continuously; `sample_ch` sequence is 0,1,…,11,0,…; `frame_start` is high once per 12 clk.
- No backpressure: the mixer must consume one sample per clk.

## Structure
- `wts_pkg` holds:
  - `WTS_CH_NUM = 12`, `WTS_FREQ_W = 12`, `WTS_PTR_W = 5`, `WTS_SAMPLE_W = 8`, `WTS_ADDR_W = 9`;
  - the channel index type.
- One sub-module, `wts_slot_sequencer`, owns:
  - the 0..11 slot counter;
  - the stage-1 delayed channel index;
  - the `frame_start` generation.
- Per-channel state is a register array inside `wts_tone_generator`, not RAM, because it needs a same-clk read-modify-write.

## Test plan
1. **Reset:** hold `nreset` = 0 for 5 clk, release. `sample_valid` first rises 2 clk later with `sample_ch` = 0. `frame_start` pulses every 12 clk. All samples are 0 while `key_on` = 0.
2. **Fastest step:** F = 0 and `key_on[3]` = 1, RAM holds `data = addr[4:0]`. Channel 3 samples read 0,1,2,…,31,0 on successive frames, and `wave_address` = `{4'd3, ptr}`.
3. **Slow step:** F = 2 on channel 11. Each pointer value repeats for exactly 3 frames, and `ptr` wraps 31→0 after 96 frames.
4. **Write to channel being serviced:** write F = 5 to channel 0 while channel 0 holds F = 1. Reload uses 1 this cycle; the following interval is 6 frames.
5. **Key-off/on:** key-off channel 7 mid-waveform at `ptr` = 17. Next channel-7 sample = 0. Re-key-on: first sample read from `ptr` = 0.
6. **Invalid channel / async reset:** write to `ch` = 13 changes no channel. Asserting `nreset` mid-frame clears all state and outputs immediately.
